// File: rtl/multicycle_alu.sv
// multicycle_alu
//   Handshaked ALU. A request is accepted when in_valid meets in_ready (IDLE).
//   Single-cycle operations present their result one cycle after accept.
//   With the ALU_MULDIV_EN macro defined, MUL / DIVU / REMU run on an
//   iterative unit for WIDTH cycles in state BUSY before the result appears.
//   The result is held in DONE until out_ready is seen.
//
// Optional feature macro: ALU_MULDIV_EN (iterative multiply/divide unit).
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high reset
//   in_valid      request present
//   in_ready      high only in IDLE
//   regA, regB    operands (sampled at accept)
//   aluoperation  4-bit operation code (sampled at accept)
//   out_valid     high only in DONE
//   out_ready     consumer takes result (only meaningful in DONE)
//   regD          registered result
//   zero          regD == 0
//   lt, gt        unsigned compare of the captured operands
//   busy          high in BUSY (tied low without the multiply/divide unit)

module multicycle_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] regA,
    input  logic [WIDTH-1:0] regB,
    input  logic [3:0]       aluoperation,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] regD,
    output logic             zero,
    output logic             lt,
    output logic             gt,
    output logic             busy
);

    localparam logic [3:0] OP_OR  = 4'b0000;
    localparam logic [3:0] OP_AND = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] result_reg;
    logic             zero_reg, lt_reg, gt_reg;

    logic             accept;
    logic             is_multi;
    logic             busy_done;
    logic             in_lt, in_gt;
    logic [WIDTH-1:0] single_result;

    assign accept = in_valid && (state_reg == IDLE);
    assign in_lt  = regA < regB;
    assign in_gt  = regA > regB;

    // Single-cycle datapath works straight off the live inputs; its output
    // is registered on the accept edge, which is what captures the operands.
    always_comb begin
        single_result = regA + regB;
        case (aluoperation)
            OP_OR:   single_result = regA | regB;
            OP_AND:  single_result = regA & regB;
            OP_ADD:  single_result = regA + regB;
            OP_XOR:  single_result = regA ^ regB;
            OP_SUB:  single_result = regA - regB;
            OP_SLT:  single_result = {{(WIDTH-1){1'b0}}, in_lt};
            default: single_result = regA + regB;
        endcase
    end

`ifdef ALU_MULDIV_EN
    localparam logic [3:0] OP_MUL  = 4'b0011;
    localparam logic [3:0] OP_DIVU = 4'b0101;
    localparam logic [3:0] OP_REMU = 4'b1000;
    localparam int         CW      = $clog2(WIDTH + 1);

    // Shared iteration registers:
    //   MUL : acc = partial product, a_work = multiplier (>>), b_work = multiplicand (<<)
    //   DIV : acc = remainder, a_work = dividend shifting out / quotient shifting in,
    //         b_work = divisor
    logic [3:0]       op_reg;
    logic [WIDTH-1:0] acc_reg, a_work_reg, b_work_reg;
    logic [CW-1:0]    count_reg;
    logic             lt_pend_reg, gt_pend_reg;

    logic [WIDTH-1:0] acc_step, a_step, b_step;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] rem_sub;
    logic [WIDTH-1:0] muldiv_result;
    logic             last_step;

    assign is_multi  = (aluoperation == OP_MUL) || (aluoperation == OP_DIVU)
                    || (aluoperation == OP_REMU);
    assign last_step = (count_reg == CW'(WIDTH - 1));
    assign busy_done = last_step;

    always_comb begin
        acc_step  = acc_reg;
        a_step    = a_work_reg;
        b_step    = b_work_reg;
        rem_shift = {acc_reg, a_work_reg[WIDTH-1]};
        rem_sub   = rem_shift[WIDTH-1:0] - b_work_reg;
        if (op_reg == OP_MUL) begin
            acc_step = acc_reg + (a_work_reg[0] ? b_work_reg : '0);
            a_step   = a_work_reg >> 1;
            b_step   = b_work_reg << 1;
        end else begin
            // Restoring division. A zero divisor always "fits", which
            // naturally yields an all-ones quotient and remainder == dividend.
            a_step = {a_work_reg[WIDTH-2:0], 1'b0};
            if (rem_shift >= {1'b0, b_work_reg}) begin
                acc_step  = rem_sub;
                a_step[0] = 1'b1;
            end else begin
                acc_step = rem_shift[WIDTH-1:0];
            end
        end
        muldiv_result = (op_reg == OP_DIVU) ? a_step : acc_step;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_reg      <= '0;
            acc_reg     <= '0;
            a_work_reg  <= '0;
            b_work_reg  <= '0;
            count_reg   <= '0;
            lt_pend_reg <= 1'b0;
            gt_pend_reg <= 1'b0;
        end else if (accept) begin
            op_reg      <= aluoperation;
            acc_reg     <= '0;
            a_work_reg  <= regA;
            b_work_reg  <= regB;
            count_reg   <= '0;
            lt_pend_reg <= in_lt;
            gt_pend_reg <= in_gt;
        end else if (state_reg == BUSY) begin
            acc_reg    <= acc_step;
            a_work_reg <= a_step;
            b_work_reg <= b_step;
            count_reg  <= count_reg + CW'(1);
        end
    end

    assign busy = (state_reg == BUSY);
`else
    assign is_multi  = 1'b0;
    assign busy_done = 1'b1;
    assign busy      = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid) state_next = is_multi ? BUSY : DONE;
            BUSY:    if (busy_done) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            result_reg <= '0;
            zero_reg   <= 1'b0;
            lt_reg     <= 1'b0;
            gt_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept && !is_multi) begin
                result_reg <= single_result;
                zero_reg   <= (single_result == '0);
                lt_reg     <= in_lt;
                gt_reg     <= in_gt;
            end
`ifdef ALU_MULDIV_EN
            else if ((state_reg == BUSY) && last_step) begin
                result_reg <= muldiv_result;
                zero_reg   <= (muldiv_result == '0);
                lt_reg     <= lt_pend_reg;
                gt_reg     <= gt_pend_reg;
            end
`endif
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign regD      = result_reg;
    assign zero      = zero_reg;
    assign lt        = lt_reg;
    assign gt        = gt_reg;

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed testbench for multicycle_alu (WIDTH = 32). Inputs change 1 ns
// after a rising edge and outputs are sampled there as well.

module tb_multicycle_alu;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] regA;
    logic [31:0] regB;
    logic [3:0]  aluoperation;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] regD;
    logic        zero;
    logic        lt;
    logic        gt;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;

    multicycle_alu #(.WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .regA         (regA),
        .regB         (regB),
        .aluoperation (aluoperation),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .regD         (regD),
        .zero         (zero),
        .lt           (lt),
        .gt           (gt),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request in IDLE, let it be accepted, then wait (bounded) for
    // out_valid. lat counts edges from accept (1 = visible right after accept).
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
        aluoperation = op;
        regA         = a;
        regB         = b;
        in_valid     = 1'b1;
        tick();
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 60) begin
            tick();
            lat++;
        end
        $display("op=%b a=%h b=%h -> regD=%h zero=%b lt=%b gt=%b latency=%0d",
                 op, a, b, regD, zero, lt, gt, lat);
    endtask

    logic [3:0]  t_op  [7];
    logic [31:0] t_a   [7];
    logic [31:0] t_b   [7];
    logic [31:0] t_res [7];
    logic        t_lt  [7];
    logic        t_gt  [7];
    int          lat;
    int          seen_valid;

    initial begin
        t_op  = '{4'b0000, 4'b0001, 4'b0100, 4'b0110, 4'b0010, 4'b1111, 4'b0111};
        t_a   = '{32'hF0F0_0000, 32'hFF00_FF00, 32'hAAAA_5555, 32'd3, 32'h7FFF_FFFF, 32'd1, 32'd5};
        t_b   = '{32'h0000_0F0F, 32'h0FF0_0FF0, 32'hFFFF_0000, 32'd5, 32'd1, 32'd2, 32'd2};
        t_res = '{32'hF0F0_0F0F, 32'h0F00_0F00, 32'h5555_5555, 32'hFFFF_FFFE, 32'h8000_0000, 32'd3, 32'd0};
        t_lt  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        t_gt  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        reset        = 1'b1;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        regA         = '0;
        regB         = '0;
        aluoperation = '0;
        tick();
        tick();
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_regD", regD, 32'd0);
        check("reset_flags", {28'd0, zero, lt, gt, busy}, 32'd0);
        reset = 1'b0;
        tick();

        // ADD wrap to zero, latency 1
        out_ready = 1'b1;
        run_op(4'b0010, 32'hFFFF_FFFF, 32'd1, lat);
        check("add_wrap_latency", 32'(lat), 32'd1);
        check("add_wrap_regD", regD, 32'd0);
        check("add_wrap_flags", {29'd0, zero, lt, gt}, 32'b101);
        check("add_wrap_in_ready", 32'(in_ready), 32'd0);
        tick();
        check("add_wrap_back_idle", {30'd0, in_ready, out_valid}, 32'b10);
        check("add_wrap_hold_regD", regD, 32'd0);

        // SLT 3 vs 3, then SLT 2 vs 5 back to back; new operands appear
        // right after the first accept and must not affect its result.
        aluoperation = 4'b0111;
        regA         = 32'd3;
        regB         = 32'd3;
        in_valid     = 1'b1;
        tick();
        regA = 32'd2;
        regB = 32'd5;
        $display("slt 3,3 -> regD=%h lt=%b gt=%b", regD, lt, gt);
        check("slt_eq_valid", 32'(out_valid), 32'd1);
        check("slt_eq_regD", regD, 32'd0);
        check("slt_eq_flags", {30'd0, lt, gt}, 32'b00);
        tick();
        check("slt_eq_release", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        $display("slt 2,5 -> regD=%h lt=%b gt=%b", regD, lt, gt);
        check("slt_lt_valid", 32'(out_valid), 32'd1);
        check("slt_lt_regD", regD, 32'd1);
        check("slt_lt_flags", {30'd0, lt, gt}, 32'b10);
        tick();

        // SUB with output back-pressure; operand wiggling is ignored
        out_ready = 1'b0;
        run_op(4'b0110, 32'd10, 32'd4, lat);
        check("sub_latency", 32'(lat), 32'd1);
        for (int i = 0; i < 5; i++) begin
            regA = 32'($urandom);
            regB = 32'($urandom);
            check("sub_hold_regD", regD, 32'd6);
            check("sub_hold_state", {30'd0, out_valid, in_ready}, 32'b10);
            tick();
        end
        out_ready = 1'b1;
        check("sub_release_valid", 32'(out_valid), 32'd1);
        tick();
        check("sub_after_release", {30'd0, out_valid, in_ready}, 32'b01);

        // Table of single-cycle operations
        for (int i = 0; i < 7; i++) begin
            run_op(t_op[i], t_a[i], t_b[i], lat);
            check($sformatf("tbl%0d_latency", i), 32'(lat), 32'd1);
            check($sformatf("tbl%0d_regD", i), regD, t_res[i]);
            check($sformatf("tbl%0d_flags", i), {29'd0, zero, lt, gt},
                  {29'd0, (t_res[i] == 32'd0), t_lt[i], t_gt[i]});
            tick();
        end

        // Reset beats out_ready in DONE: pending result is dropped
        run_op(4'b0010, 32'd20, 32'd22, lat);
        check("rst_done_pre", regD, 32'd42);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        $display("reset in DONE -> regD=%h out_valid=%b in_ready=%b", regD, out_valid, in_ready);
        check("rst_done_regD", regD, 32'd0);
        check("rst_done_state", {30'd0, out_valid, in_ready}, 32'b01);

        // Reset beats accept in the same cycle
        aluoperation = 4'b0010;
        regA         = 32'd9;
        regB         = 32'd9;
        in_valid     = 1'b1;
        reset        = 1'b1;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        $display("reset with accept -> regD=%h out_valid=%b", regD, out_valid);
        check("rst_accept_state", {30'd0, out_valid, in_ready}, 32'b01);
        check("rst_accept_regD", regD, 32'd0);
        tick();
        check("rst_accept_no_valid", 32'(out_valid), 32'd0);

`ifdef ALU_MULDIV_EN
        // MUL: busy for exactly 32 cycles, result at accept+33
        aluoperation = 4'b0011;
        regA         = 32'h0001_0000;
        regB         = 32'h0001_0001;
        in_valid     = 1'b1;
        tick();
        in_valid = 1'b0;
        regA     = '0;
        regB     = '0;
        for (int i = 1; i <= 32; i++) begin
            check($sformatf("mul_busy_c%0d", i), {30'd0, busy, out_valid}, 32'b10);
            tick();
        end
        $display("mul 0x10000*0x10001 -> regD=%h busy=%b out_valid=%b", regD, busy, out_valid);
        check("mul_done_state", {30'd0, busy, out_valid}, 32'b01);
        check("mul_regD", regD, 32'h0001_0000);
        tick();

        run_op(4'b0101, 32'd7, 32'd0, lat);
        check("divu_by0_latency", 32'(lat), 32'd33);
        check("divu_by0_regD", regD, 32'hFFFF_FFFF);
        tick();
        run_op(4'b1000, 32'd7, 32'd0, lat);
        check("remu_by0_latency", 32'(lat), 32'd33);
        check("remu_by0_regD", regD, 32'd7);
        check("remu_by0_flags", {29'd0, zero, lt, gt}, 32'b001);
        tick();
        run_op(4'b0101, 32'd100, 32'd7, lat);
        check("divu_latency", 32'(lat), 32'd33);
        check("divu_regD", regD, 32'd14);
        tick();
        run_op(4'b1000, 32'd100, 32'd7, lat);
        check("remu_regD", regD, 32'd2);
        tick();

        // Reset during cycle 10 of a MUL
        aluoperation = 4'b0011;
        regA         = 32'd1234;
        regB         = 32'd5678;
        in_valid     = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        check("mul_abort_busy_pre", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        $display("reset in BUSY -> regD=%h busy=%b in_ready=%b", regD, busy, in_ready);
        check("mul_abort_outputs", {26'd0, zero, lt, gt, busy, out_valid, in_ready}, 32'b000001);
        check("mul_abort_regD", regD, 32'd0);
        seen_valid = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen_valid++;
            tick();
        end
        check("mul_abort_no_valid", 32'(seen_valid), 32'd0);
        run_op(4'b0010, 32'd1, 32'd2, lat);
        check("mul_abort_add_lat", 32'(lat), 32'd1);
        check("mul_abort_add_regD", regD, 32'd3);
        tick();
`else
        // Without the multiply/divide unit these codes execute as ADD
        run_op(4'b0011, 32'd5, 32'd6, lat);
        check("code3_latency", 32'(lat), 32'd1);
        check("code3_regD", regD, 32'd11);
        check("code3_busy", 32'(busy), 32'd0);
        tick();
        run_op(4'b0101, 32'd100, 32'd7, lat);
        check("code5_regD", regD, 32'd107);
        check("code5_latency", 32'(lat), 32'd1);
        tick();
        run_op(4'b1000, 32'd7, 32'd0, lat);
        check("code8_regD", regD, 32'd7);
        check("code8_busy", 32'(busy), 32'd0);
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
